intc_vector_fetcher: RTL and testbench
======================================

Name: intc_vector_fetcher

Overview:
- AXI-Lite master that sits between the interrupt controller's irq output and a CPU-side consumer.
- After reset it programs the controller (MER, IER), then services interrupts.
- On each irq it reads IVR to get the winning vector, presents the vector through a valid/ready handshake, and acknowledges it by writing IAR.
- It drives the slave end of the controller's AXI-Lite port and lets a simple core or DMA take vectored interrupts without software polling.

Parameters:
- BASE_ADDR, 32'h0, byte address of the controller register block.
- NUM_INTR, 8, number of controller inputs (1..32); width of the vector index.
- IER_INIT, 32'hFF, value written to IER at init.
- VEC_W, $clog2(NUM_INTR) (minimum 1), width of vec_o.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- irq_i  in  1  level interrupt from controller
- m_aw_addr  out  32  write address
- m_aw_valid  out  1
- m_aw_ready  in  1
- m_w_data  out  32
- m_w_strb  out  4  always 4'hF
- m_w_valid  out  1
- m_w_ready  in  1
- m_b_resp  in  2
- m_b_valid  in  1
- m_b_ready  out  1
- m_ar_addr  out  32
- m_ar_valid  out  1
- m_ar_ready  in  1
- m_r_data  in  32
- m_r_resp  in  2
- m_r_valid  in  1
- m_r_ready  out  1
- vec_o  out  VEC_W  interrupt index
- vec_valid_o  out  1
- vec_ready_i  in  1
- init_done_o  out  1  high once init writes complete
- err_o  out  1  one-cycle pulse on SLVERR/DECERR

Behaviour:
- Reset values: all valid/ready outputs 0, addresses/data 0, vec_o 0, init_done_o 0, err_o 0.
- Reset is sampled on the aclk edge only. Reset mid-transaction abandons it and restarts init.
- Register offsets: IVR 0x18, IAR 0x0C, IER 0x08, MER 0x1C.
- Write sequence (WR_AW state):
  - Assert aw_valid and w_valid together with stable addr/data.
  - Each valid drops independently after its own handshake.
  - Once both have been accepted, go to WR_B.
  - WR_B: b_ready=1; on b_valid, go to the next state.
- Read sequence:
  - RD_AR: ar_valid=1 until ar_ready.
  - RD_R: r_ready=1; capture r_data on r_valid.
- FSM:
  - INIT_MER: write 0x3 to MER.
  - INIT_IER: write IER_INIT to IER.
  - IDLE: init_done_o=1. If irq_i=1, go to RD_AR with ar_addr=BASE+0x18.
  - RD_R, depending on the captured data:
    - 32'hFFFFFFFF (no active interrupt): back to IDLE.
    - Value ≥ NUM_INTR: err_o pulse, back to IDLE.
    - Otherwise: latch vec_o = data[VEC_W-1:0] and go to PRESENT.
  - PRESENT: vec_valid_o=1, vec_o stable. On vec_ready_i, vec_valid_o drops the next cycle; go to ACK with data = 1<<vec_o, addr = BASE+0x0C.
  - ACK: write sequence, then IDLE.
- irq_i is re-sampled only in IDLE. It is ignored during other states, and a level still high after ACK triggers a new fetch.
- Minimum IDLE to vec_valid_o latency with zero-wait slave: 3 cycles (AR accept, R capture, PRESENT).
- A nonzero b_resp or r_resp pulses err_o for 1 cycle:
  - During init: the FSM still advances; init_done_o asserts anyway.
  - During fetch: return to IDLE without presenting.
  - During ACK: return to IDLE.
- aw_ready and w_ready may arrive in the same cycle or in any order. A b_valid arriving in the same cycle as the last accept is not lost, because b_ready is asserted from WR_B entry.
- vec_ready_i held high before valid: the handshake completes in the first PRESENT cycle.
- No more than one outstanding transaction, ever.

Test Plan:
- Reset, zero-wait slave model -> writes MER=0x3 at BASE+0x1C then IER=0xFF at BASE+0x08, in order; init_done_o rises after the second B.
- irq_i=1, IVR returns 5, vec_ready_i=1 -> vec_valid_o with vec_o=5 three cycles after IDLE; then IAR write data 0x20 at BASE+0x0C.
- IVR returns 0xFFFFFFFF -> no vec_valid_o, no IAR write, back in IDLE.
- aw_ready delayed 3 cycles after w_ready, with b_valid the same cycle as aw accept -> single write completes; no duplicate AW/W beats.
- r_resp=2'b10 on IVR read -> err_o 1-cycle pulse, no vector presented; a subsequent irq is serviced normally.
- aresetn low while in PRESENT with vec_ready_i=0 -> vec_valid_o=0 next edge; init sequence repeats.

Source files
------------

// File: rtl/intc_vector_fetcher.sv
// intc_vector_fetcher: AXI-Lite master that initialises the interrupt controller, then fetches, presents and acknowledges vectors
module intc_vector_fetcher #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int NUM_INTR = 8,
  parameter logic [31:0] IER_INIT = 32'hFF,
  parameter int VEC_W = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             irq_i,
  output logic [31:0]      m_aw_addr,
  output logic             m_aw_valid,
  input  logic             m_aw_ready,
  output logic [31:0]      m_w_data,
  output logic [3:0]       m_w_strb,
  output logic             m_w_valid,
  input  logic             m_w_ready,
  input  logic [1:0]       m_b_resp,
  input  logic             m_b_valid,
  output logic             m_b_ready,
  output logic [31:0]      m_ar_addr,
  output logic             m_ar_valid,
  input  logic             m_ar_ready,
  input  logic [31:0]      m_r_data,
  input  logic [1:0]       m_r_resp,
  input  logic             m_r_valid,
  output logic             m_r_ready,
  output logic [VEC_W-1:0] vec_o,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic             init_done_o,
  output logic             err_o
);
  localparam logic [2:0] INIT_MER = 3'd0, WR_AW = 3'd1, WR_B = 3'd2, IDLE = 3'd3,
                         RD_AR = 3'd4, RD_R = 3'd5, PRESENT = 3'd6;
  logic [2:0] state;
  logic       wr_mer;
  assign m_w_strb = 4'hF;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      state       <= INIT_MER;
      wr_mer      <= 1'b0;
      m_aw_addr   <= '0;
      m_aw_valid  <= 1'b0;
      m_w_data    <= '0;
      m_w_valid   <= 1'b0;
      m_b_ready   <= 1'b0;
      m_ar_addr   <= '0;
      m_ar_valid  <= 1'b0;
      m_r_ready   <= 1'b0;
      vec_o       <= '0;
      vec_valid_o <= 1'b0;
      init_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        INIT_MER: begin
          m_aw_addr  <= BASE_ADDR + 32'h1C;
          m_w_data   <= 32'h3;
          m_aw_valid <= 1'b1;
          m_w_valid  <= 1'b1;
          wr_mer     <= 1'b1;
          state      <= WR_AW;
        end
        WR_AW: begin
          if (m_aw_ready) m_aw_valid <= 1'b0;
          if (m_w_ready) m_w_valid <= 1'b0;
          if ((!m_aw_valid || m_aw_ready) && (!m_w_valid || m_w_ready)) begin
            m_b_ready <= 1'b1;
            state     <= WR_B;
          end
        end
        WR_B: if (m_b_valid) begin
          m_b_ready <= 1'b0;
          err_o     <= |m_b_resp;
          // A bad response never stalls init: the IER write and init_done follow regardless
          if (wr_mer) begin
            m_aw_addr  <= BASE_ADDR + 32'h08;
            m_w_data   <= IER_INIT;
            m_aw_valid <= 1'b1;
            m_w_valid  <= 1'b1;
            wr_mer     <= 1'b0;
            state      <= WR_AW;
          end else begin
            init_done_o <= 1'b1;
            state       <= IDLE;
          end
        end
        IDLE: if (irq_i) begin
          m_ar_addr  <= BASE_ADDR + 32'h18;
          m_ar_valid <= 1'b1;
          state      <= RD_AR;
        end
        RD_AR: if (m_ar_ready) begin
          m_ar_valid <= 1'b0;
          m_r_ready  <= 1'b1;
          state      <= RD_R;
        end
        RD_R: if (m_r_valid) begin
          m_r_ready <= 1'b0;
          if (|m_r_resp || (m_r_data != 32'hFFFF_FFFF && m_r_data >= 32'(NUM_INTR))) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else if (m_r_data == 32'hFFFF_FFFF) begin
            state <= IDLE;
          end else begin
            vec_o       <= m_r_data[VEC_W-1:0];
            vec_valid_o <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: if (vec_ready_i) begin
          vec_valid_o <= 1'b0;
          m_aw_addr   <= BASE_ADDR + 32'h0C;
          m_w_data    <= 32'd1 << vec_o;
          m_aw_valid  <= 1'b1;
          m_w_valid   <= 1'b1;
          state       <= WR_AW;
        end
        default: state <= INIT_MER;
      endcase
    end
endmodule

// File: tb/tb_intc_vector_fetcher.sv
// tb_intc_vector_fetcher: randomized AXI-Lite slave plus spec-level model of init, fetch, present and acknowledge
module tb_intc_vector_fetcher;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int NUM = 8;
  localparam int VW = 3;
  logic aclk = 1'b0, aresetn = 1'b0, irq_i = 1'b0, vec_ready_i = 1'b0;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic [3:0] m_w_strb;
  logic [1:0] m_b_resp, m_r_resp;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [VW-1:0] vec_o;
  logic vec_valid_o, init_done_o, err_o;
  int total = 0, bad = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0, r_beats = 0;
  int vv_cycles = 0, err_pulses = 0, err_long = 0;
  logic err_prev = 1'b0;
  logic have_aw = 1'b0, have_w = 1'b0, have_ar = 1'b0;
  logic [31:0] aw_a = '0, w_d = '0, ar_last = '0, ivr_val = '0;
  logic [1:0] r_resp_k = '0, b_resp_k = '0;
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic aw_hs, w_hs, ar_hs;

  intc_vector_fetcher #(.BASE_ADDR(BASE), .NUM_INTR(NUM), .IER_INIT(32'hFF)) dut (
    .aclk(aclk), .aresetn(aresetn), .irq_i(irq_i),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .vec_o(vec_o), .vec_valid_o(vec_valid_o), .vec_ready_i(vec_ready_i),
    .init_done_o(init_done_o), .err_o(err_o)
  );

  always #5 aclk = ~aclk;

  // Slave: each ready rises after its programmed wait; B may coincide with the last accept
  assign m_aw_ready = m_aw_valid && (aw_c >= aw_dly);
  assign m_w_ready  = m_w_valid && (w_c >= w_dly);
  assign m_ar_ready = m_ar_valid && (ar_c >= ar_dly);
  assign aw_hs = m_aw_valid && m_aw_ready;
  assign w_hs  = m_w_valid && m_w_ready;
  assign ar_hs = m_ar_valid && m_ar_ready;
  assign m_b_valid = (have_aw || aw_hs) && (have_w || w_hs) && (b_c >= b_dly);
  assign m_b_resp  = m_b_valid ? b_resp_k : 2'b00;
  assign m_r_valid = have_ar && (r_c >= r_dly);
  assign m_r_data  = m_r_valid ? ivr_val : 32'h0;
  assign m_r_resp  = m_r_valid ? r_resp_k : 2'b00;

  always @(posedge aclk)
    if (!aresetn) begin
      have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
      aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
    end else begin
      aw_c <= aw_hs ? 0 : m_aw_valid ? aw_c + 1 : 0;
      w_c  <= w_hs ? 0 : m_w_valid ? w_c + 1 : 0;
      ar_c <= ar_hs ? 0 : m_ar_valid ? ar_c + 1 : 0;
      if (aw_hs) begin have_aw <= 1'b1; aw_a <= m_aw_addr; aw_beats <= aw_beats + 1; end
      if (w_hs) begin have_w <= 1'b1; w_d <= m_w_data; w_beats <= w_beats + 1; end
      if (m_b_valid && m_b_ready) begin
        have_aw <= 1'b0; have_w <= 1'b0; b_c <= 0;
        wr_addr_q.push_back(aw_a); wr_data_q.push_back(w_d);
      end else if (have_aw && have_w && !m_b_valid) b_c <= b_c + 1;
      if (ar_hs) begin have_ar <= 1'b1; ar_last <= m_ar_addr; ar_beats <= ar_beats + 1; r_c <= 0; end
      else if (m_r_valid && m_r_ready) begin have_ar <= 1'b0; r_c <= 0; r_beats <= r_beats + 1; end
      else if (have_ar && !m_r_valid) r_c <= r_c + 1;
    end

  always @(negedge aclk) begin
    if (vec_valid_o) vv_cycles++;
    if (err_o && !err_prev) err_pulses++;
    if (err_o && err_prev) err_long++;
    err_prev = err_o;
  end

  task automatic reset_and_init(input int exp_err);
    int t, w0, e0;
    aresetn = 1'b0; irq_i = 1'b0; vec_ready_i = 1'b0;
    @(negedge aclk);
    total++;
    if ({m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready, vec_valid_o, init_done_o, err_o} !== 8'h0 ||
        m_aw_addr !== 32'h0 || m_w_data !== 32'h0 || m_ar_addr !== 32'h0 || vec_o !== '0) begin
      bad++;
      $display("FAIL reset_state: valids=%b aw=%h w=%h ar=%h vec=%h required all zero",
               {m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready, vec_valid_o, init_done_o, err_o},
               m_aw_addr, m_w_data, m_ar_addr, vec_o);
    end
    @(negedge aclk);
    w0 = wr_addr_q.size(); e0 = err_pulses; t = 0;
    aresetn = 1'b1;
    while (!init_done_o && t < 100) begin @(negedge aclk); t++; end
    total++;
    if (t >= 100) begin bad++; $display("FAIL init_timeout: init_done_o=%b required 1", init_done_o); end
    total++;
    if (wr_addr_q.size() != w0 + 2) begin
      bad++; $display("FAIL init_writes: count=%0d when init_done rose, required 2", wr_addr_q.size() - w0);
    end else begin
      total++;
      if (wr_addr_q[w0] !== BASE + 32'h1C || wr_data_q[w0] !== 32'h3) begin
        bad++; $display("FAIL init_mer: addr=%h data=%h required %h/3", wr_addr_q[w0], wr_data_q[w0], BASE + 32'h1C);
      end
      if (wr_addr_q[w0+1] !== BASE + 32'h08 || wr_data_q[w0+1] !== 32'hFF) begin
        bad++; $display("FAIL init_ier: addr=%h data=%h required %h/ff", wr_addr_q[w0+1], wr_data_q[w0+1], BASE + 32'h08);
      end
    end
    repeat (3) @(negedge aclk);
    total++;
    if (err_pulses - e0 != exp_err || init_done_o !== 1'b1) begin
      bad++; $display("FAIL init_err: pulses=%0d done=%b required %0d/1", err_pulses - e0, init_done_o, exp_err);
    end
  endtask

  task automatic fetch(input logic [31:0] ivr, input logic [1:0] rr, input logic [1:0] br,
                       input bit pre, input int hold, output int lat);
    bit pres;
    int t, a0, r0, e0, v0, w0, aw0, wb0, xe;
    pres = (rr == 2'b00) && (ivr < NUM);
    xe = ((rr != 2'b00) || (ivr != 32'hFFFF_FFFF && ivr >= NUM)) ? 1 : 0;
    if (pres && br != 2'b00) xe++;
    ivr_val = ivr; r_resp_k = rr; b_resp_k = br; vec_ready_i = pre;
    a0 = ar_beats; r0 = r_beats; e0 = err_pulses; v0 = vv_cycles;
    w0 = wr_addr_q.size(); aw0 = aw_beats; wb0 = w_beats; t = 0;
    irq_i = 1'b1;
    while (t < 80 && !(pres ? vec_valid_o : (r_beats != r0))) begin
      @(negedge aclk); t++;
      if (ar_beats != a0) irq_i = 1'b0;
    end
    irq_i = 1'b0; lat = t;
    total++;
    if (t >= 80) begin bad++; $display("FAIL fetch_timeout: ivr=%h vec_valid=%b reads=%0d", ivr, vec_valid_o, r_beats - r0); end
    total++;
    if (ar_last !== BASE + 32'h18) begin bad++; $display("FAIL ivr_addr: got %h required %h", ar_last, BASE + 32'h18); end
    if (pres) begin
      total++;
      if (vec_o !== ivr[VW-1:0]) begin bad++; $display("FAIL vec_value: got %0d required %0d", vec_o, ivr[VW-1:0]); end
      if (!pre) begin
        for (int i = 0; i < hold; i++) begin
          @(negedge aclk); total++;
          if (vec_valid_o !== 1'b1 || vec_o !== ivr[VW-1:0]) begin
            bad++; $display("FAIL present_hold: valid=%b vec=%0d required 1/%0d", vec_valid_o, vec_o, ivr[VW-1:0]);
          end
        end
        vec_ready_i = 1'b1;
      end
      @(negedge aclk);
      vec_ready_i = 1'b0;
      total++;
      if (vec_valid_o !== 1'b0) begin bad++; $display("FAIL valid_drop: vec_valid_o=%b required 0", vec_valid_o); end
      t = 0;
      while (wr_addr_q.size() == w0 && t < 80) begin @(negedge aclk); t++; end
      repeat (3) @(negedge aclk);
      total++;
      if (wr_addr_q.size() != w0 + 1) begin
        bad++; $display("FAIL ack_count: writes=%0d required 1", wr_addr_q.size() - w0);
      end else begin
        total++;
        if (wr_addr_q[w0] !== BASE + 32'h0C || wr_data_q[w0] !== (32'd1 << ivr)) begin
          bad++; $display("FAIL ack_write: addr=%h data=%h required %h/%h", wr_addr_q[w0], wr_data_q[w0], BASE + 32'h0C, 32'd1 << ivr);
        end
      end
      total++;
      if (vv_cycles - v0 != (pre ? 1 : hold + 1)) begin
        bad++; $display("FAIL valid_cycles: got %0d required %0d", vv_cycles - v0, pre ? 1 : hold + 1);
      end
      total++;
      if (aw_beats - aw0 != 1 || w_beats - wb0 != 1) begin
        bad++; $display("FAIL beats: aw=%0d w=%0d required 1/1", aw_beats - aw0, w_beats - wb0);
      end
    end else begin
      repeat (5) @(negedge aclk);
      total++;
      if (vv_cycles != v0 || wr_addr_q.size() != w0 || aw_beats != aw0) begin
        bad++; $display("FAIL no_present: valid_cycles=%0d writes=%0d required 0/0", vv_cycles - v0, wr_addr_q.size() - w0);
      end
    end
    total++;
    if (err_pulses - e0 != xe) begin bad++; $display("FAIL err_pulse: ivr=%h rr=%0d br=%0d got %0d required %0d", ivr, rr, br, err_pulses - e0, xe); end
    b_resp_k = 2'b00; r_resp_k = 2'b00;
  endtask

  task automatic test_reset();
    reset_and_init(0);
  endtask

  task automatic test_vector();
    int lat;
    fetch(32'd5, 2'b00, 2'b00, 1'b1, 0, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL latency: got %0d cycles required 3", lat); end
    fetch(32'd0, 2'b00, 2'b00, 1'b0, 2, lat);
    fetch(32'd7, 2'b00, 2'b00, 1'b0, 0, lat);
  endtask

  task automatic test_no_active();
    int lat;
    fetch(32'hFFFF_FFFF, 2'b00, 2'b00, 1'b1, 0, lat);
    fetch(32'd8, 2'b00, 2'b00, 1'b1, 0, lat);
  endtask

  task automatic test_write_skew();
    int lat;
    aw_dly = 3; w_dly = 0; b_dly = 0;
    fetch(32'd6, 2'b00, 2'b00, 1'b0, 1, lat);
    aw_dly = 0; w_dly = 3;
    fetch(32'd3, 2'b00, 2'b00, 1'b1, 0, lat);
    w_dly = 0;
  endtask

  task automatic test_resp_errors();
    int lat;
    fetch(32'd3, 2'b10, 2'b00, 1'b1, 0, lat);
    fetch(32'd2, 2'b00, 2'b00, 1'b1, 0, lat);
    fetch(32'd4, 2'b00, 2'b11, 1'b0, 1, lat);
    fetch(32'd1, 2'b00, 2'b00, 1'b1, 0, lat);
  endtask

  task automatic test_init_errors();
    aw_dly = 1; w_dly = 2; b_dly = 1;
    b_resp_k = 2'b10;
    reset_and_init(2);
    b_resp_k = 2'b00; aw_dly = 0; w_dly = 0; b_dly = 0;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    ivr_val = 32'd4; vec_ready_i = 1'b0; irq_i = 1'b1;
    while (!vec_valid_o && t < 50) begin @(negedge aclk); t++; if (ar_beats > 0 && m_r_ready) irq_i = 1'b0; end
    irq_i = 1'b0;
    total++;
    if (t >= 50) begin bad++; $display("FAIL mid_present: vec_valid_o=%b required 1", vec_valid_o); end
    reset_and_init(0);
  endtask

  task automatic test_random();
    int lat, k;
    logic [31:0] v;
    logic [1:0] rr, br;
    for (int n = 0; n < 25; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      v = (k <= 5) ? 32'($urandom_range(0, NUM - 1)) : (k == 6) ? 32'hFFFF_FFFF :
          (k == 7) ? 32'($urandom_range(NUM, 40)) : (k == 8) ? $urandom : 32'($urandom_range(0, NUM - 1));
      rr = (k == 9) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch(v, rr, br, 1'($urandom_range(0, 1)), $urandom_range(0, 3), lat);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_no_active();
    test_write_skew();
    test_resp_errors();
    test_init_errors();
    test_reset_mid();
    test_random();
    total++;
    if (err_long != 0) begin bad++; $display("FAIL err_width: long pulses=%0d required 0", err_long); end
    total++;
    if (aw_beats != w_beats || m_w_strb !== 4'hF) begin
      bad++; $display("FAIL beat_pairing: aw=%0d w=%0d strb=%h required equal/f", aw_beats, w_beats, m_w_strb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
